// File: rtl/path_switch_ctrl_pkg.sv
// Shared types and width helpers for the dual-path CDC switch controller.
package path_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_FIFO,
    S_L2H,
    S_DRAIN,
    S_SWRST
  } state_e;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_L2H  = 1'b1;

  localparam int unsigned DEB_MAX = 15;
  localparam int unsigned DEB_W   = $clog2(DEB_MAX + 1);

  // The shared timer counts down from (longest interval - 1).
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/path_switch_ctrl_if.sv
// Measurement, datapath-control and write-gating signals of path_switch_ctrl.
// PATH_SWITCH_FORCE_EN adds force_en/force_l2h.
interface path_switch_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             meas_vld;
  logic [CNT_W-1:0] freq1;
  logic [CNT_W-1:0] freq2;
  logic             fifo_empty;
  logic             wr_req;
  logic             wr_en;
  logic             sel_l2h;
  logic             fifo_rst_n;
  logic             l2h_rst_n;
  logic             busy;
  logic             drain_err;

`ifdef PATH_SWITCH_FORCE_EN
  logic             force_en;
  logic             force_l2h;

  modport master (
    output meas_vld, freq1, freq2, fifo_empty, wr_req, force_en, force_l2h,
    input  wr_en, sel_l2h, fifo_rst_n, l2h_rst_n, busy, drain_err
  );

  modport slave (
    input  meas_vld, freq1, freq2, fifo_empty, wr_req, force_en, force_l2h,
    output wr_en, sel_l2h, fifo_rst_n, l2h_rst_n, busy, drain_err
  );
`else
  modport master (
    output meas_vld, freq1, freq2, fifo_empty, wr_req,
    input  wr_en, sel_l2h, fifo_rst_n, l2h_rst_n, busy, drain_err
  );

  modport slave (
    input  meas_vld, freq1, freq2, fifo_empty, wr_req,
    output wr_en, sel_l2h, fifo_rst_n, l2h_rst_n, busy, drain_err
  );
`endif

endinterface

// File: rtl/path_switch_ctrl_debounce.sv
// Hysteresis compare of wclk/rclk counts plus debounce counter; pulses o_switch_req
// on the strobe that would bring the agreeing-measurement count to DEB_N.
module mode_debounce
  import path_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned HYST  = 4,
  parameter int unsigned DEB_N = 3
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_meas_vld,
  input  logic [CNT_W-1:0] i_freq1,
  input  logic [CNT_W-1:0] i_freq2,
  input  logic             i_cur_mode,
  output logic             o_switch_req
);

  localparam int unsigned EW = CNT_W + 1;

  logic [DEB_W-1:0] r_deb_cnt;
  logic [DEB_W-1:0] w_deb_d;
  logic [DEB_W-1:0] w_cnt_inc;
  logic [EW-1:0]    w_f1;
  logic [EW-1:0]    w_f2;
  logic [EW-1:0]    w_hyst;
  logic             w_want_l2h;
  logic             w_want_fifo;
  logic             w_want_other;

  // One extra bit so freq+HYST cannot wrap.
  assign w_f1   = {1'b0, i_freq1};
  assign w_f2   = {1'b0, i_freq2};
  assign w_hyst = EW'(HYST);

  assign w_want_l2h   = w_f2 > (w_f1 + w_hyst);
  assign w_want_fifo  = w_f1 > (w_f2 + w_hyst);
  assign w_want_other = (i_cur_mode == MODE_FIFO) ? w_want_l2h : w_want_fifo;
  assign w_cnt_inc    = r_deb_cnt + 1'b1;

  assign o_switch_req = i_en & i_meas_vld & w_want_other & (w_cnt_inc == DEB_W'(DEB_N));

  always_comb begin
    w_deb_d = r_deb_cnt;
    if (!i_en) begin
      w_deb_d = '0;
    end else if (i_meas_vld) begin
      w_deb_d = (w_want_other && !o_switch_req) ? w_cnt_inc : '0;
    end
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= w_deb_d;
    end
  end

endmodule

// File: rtl/path_switch_ctrl.sv
// Sequences FIFO <-> l2h path switching: block writes, drain, reset both paths, flip mux.
// Define PATH_SWITCH_FORCE_EN to add the force_en/force_l2h override.
module path_switch_ctrl
  import path_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned HYST      = 4,
  parameter int unsigned DEB_N     = 3,
  parameter int unsigned DRAIN_TO  = 256,
  parameter int unsigned FLUSH_CYC = 8,
  parameter int unsigned RST_CYC   = 4
) (
  input logic               wclk,
  input logic               rst,
  path_switch_ctrl_if.slave bus
);

  localparam int unsigned TMR_W = tmr_width(DRAIN_TO, FLUSH_CYC, RST_CYC);
  localparam logic [TMR_W-1:0] LD_RST   = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] LD_DRAIN = TMR_W'(DRAIN_TO - 1);
  localparam logic [TMR_W-1:0] LD_FLUSH = TMR_W'(FLUSH_CYC - 1);

  state_e           r_state, w_state_d;
  logic [TMR_W-1:0] r_tmr, w_tmr_d;
  logic             r_target, w_target_d;
  logic             r_sel, w_sel_d;
  logic             r_fifo_rst_n, w_fifo_rst_n_d;
  logic             r_l2h_rst_n, w_l2h_rst_n_d;
  logic             r_busy, w_busy_d;
  logic             r_drain_err, w_drain_err_d;
  logic             w_run;
  logic             w_cur_mode;
  logic             w_switch_req;
  logic             w_force_en;
  logic             w_force_sw;

  assign w_run      = (r_state == S_FIFO) || (r_state == S_L2H);
  assign w_cur_mode = (r_state == S_L2H) ? MODE_L2H : MODE_FIFO;

`ifdef PATH_SWITCH_FORCE_EN
  assign w_force_en = bus.force_en;
  assign w_force_sw = w_run & bus.force_en & (w_cur_mode != bus.force_l2h);
`else
  assign w_force_en = 1'b0;
  assign w_force_sw = 1'b0;
`endif

  mode_debounce #(
    .CNT_W (CNT_W),
    .HYST  (HYST),
    .DEB_N (DEB_N)
  ) u_debounce (
    .wclk         (wclk),
    .rst          (rst),
    .i_en         (w_run & ~w_force_en),
    .i_meas_vld   (bus.meas_vld),
    .i_freq1      (bus.freq1),
    .i_freq2      (bus.freq2),
    .i_cur_mode   (w_cur_mode),
    .o_switch_req (w_switch_req)
  );

  always_comb begin
    w_state_d     = r_state;
    w_tmr_d       = r_tmr;
    w_target_d    = r_target;
    w_drain_err_d = r_drain_err;
    unique case (r_state)
      S_INIT: begin
        if (r_tmr == '0) w_state_d = S_FIFO;
        else             w_tmr_d   = r_tmr - 1'b1;
      end
      S_FIFO, S_L2H: begin
        if (w_switch_req || w_force_sw) begin
          w_state_d  = S_DRAIN;
          w_target_d = ~w_cur_mode;
          w_tmr_d    = (w_cur_mode == MODE_FIFO) ? LD_DRAIN : LD_FLUSH;
        end
      end
      S_DRAIN: begin
        // Leaving FIFO waits for empty (with timeout); leaving l2h is a fixed flush.
        if ((r_target == MODE_L2H) && bus.fifo_empty) begin
          w_state_d = S_SWRST;
          w_tmr_d   = LD_RST;
        end else if (r_tmr == '0) begin
          w_state_d = S_SWRST;
          w_tmr_d   = LD_RST;
          if (r_target == MODE_L2H) w_drain_err_d = 1'b1;
        end else begin
          w_tmr_d = r_tmr - 1'b1;
        end
      end
      S_SWRST: begin
        if (r_tmr == '0) w_state_d = (r_target == MODE_L2H) ? S_L2H : S_FIFO;
        else             w_tmr_d   = r_tmr - 1'b1;
      end
      default: begin
        w_state_d = S_INIT;
        w_tmr_d   = LD_RST;
      end
    endcase
  end

  // Registered outputs follow the next state; DRAIN keeps the running path alive.
  always_comb begin
    w_sel_d        = r_sel;
    w_fifo_rst_n_d = r_fifo_rst_n;
    w_l2h_rst_n_d  = r_l2h_rst_n;
    w_busy_d       = !((w_state_d == S_FIFO) || (w_state_d == S_L2H));
    unique case (w_state_d)
      S_FIFO: begin
        w_sel_d        = MODE_FIFO;
        w_fifo_rst_n_d = 1'b1;
        w_l2h_rst_n_d  = 1'b0;
      end
      S_L2H: begin
        w_sel_d        = MODE_L2H;
        w_fifo_rst_n_d = 1'b0;
        w_l2h_rst_n_d  = 1'b1;
      end
      S_SWRST: begin
        w_sel_d        = w_target_d;
        w_fifo_rst_n_d = 1'b0;
        w_l2h_rst_n_d  = 1'b0;
      end
      S_DRAIN: ;
      default: begin
        w_sel_d        = MODE_FIFO;
        w_fifo_rst_n_d = 1'b0;
        w_l2h_rst_n_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_INIT;
      r_tmr        <= LD_RST;
      r_target     <= MODE_FIFO;
      r_sel        <= MODE_FIFO;
      r_fifo_rst_n <= 1'b0;
      r_l2h_rst_n  <= 1'b0;
      r_busy       <= 1'b1;
      r_drain_err  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_tmr        <= w_tmr_d;
      r_target     <= w_target_d;
      r_sel        <= w_sel_d;
      r_fifo_rst_n <= w_fifo_rst_n_d;
      r_l2h_rst_n  <= w_l2h_rst_n_d;
      r_busy       <= w_busy_d;
      r_drain_err  <= w_drain_err_d;
    end
  end

  assign bus.wr_en      = bus.wr_req & w_run;
  assign bus.sel_l2h    = r_sel;
  assign bus.fifo_rst_n = r_fifo_rst_n;
  assign bus.l2h_rst_n  = r_l2h_rst_n;
  assign bus.busy       = r_busy;
  assign bus.drain_err  = r_drain_err;

endmodule

// File: tb/tb_path_switch_ctrl.sv
// Directed bench for path_switch_ctrl: per-cycle vector table for bring-up and a first
// switch, then hand-written hysteresis, debounce, flush, timeout and reset sequences.
module tb_path_switch_ctrl;

  logic wclk = 1'b0;
  logic rst  = 1'b0;
  always #5 wclk = ~wclk;

  path_switch_ctrl_if #(.CNT_W(16)) bus ();

  path_switch_ctrl #(
    .CNT_W     (16),
    .HYST      (4),
    .DEB_N     (3),
    .DRAIN_TO  (256),
    .FLUSH_CYC (8),
    .RST_CYC   (4)
  ) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Output vector packing: {wr_en, sel_l2h, fifo_rst_n, l2h_rst_n, busy, drain_err}
  localparam logic [5:0] O_RST  = 6'b000010;
  localparam logic [5:0] O_FIFO = 6'b101000;
  localparam logic [5:0] O_DRN  = 6'b001010;
  localparam logic [5:0] O_SW1  = 6'b010010;
  localparam logic [5:0] O_L2H  = 6'b110100;

  typedef struct {
    logic        meas;
    logic [15:0] f2;
    logic        empty;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[24];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t mk(input logic m, input logic [15:0] f2, input logic e,
                              input logic [5:0] x);
    vec_t v;
    v.meas  = m;
    v.f2    = f2;
    v.empty = e;
    v.exp   = x;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {bus.wr_en, bus.sel_l2h, bus.fifo_rst_n, bus.l2h_rst_n, bus.busy, bus.drain_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] f1, input logic [15:0] f2);
    bus.meas_vld = 1'b1;
    bus.freq1    = f1;
    bus.freq2    = f2;
    tick();
    bus.meas_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.meas_vld   = 1'b0;
    bus.freq1      = 16'd100;
    bus.freq2      = 16'd100;
    bus.fifo_empty = 1'b0;
    bus.wr_req     = 1'b1;
`ifdef PATH_SWITCH_FORCE_EN
    bus.force_en   = 1'b0;
    bus.force_l2h  = 1'b0;
`endif

    for (int i = 0; i < 4; i++)   tbl[i] = mk(1'b0, 16'd100, 1'b0, O_RST);
    tbl[4] = mk(1'b0, 16'd100, 1'b0, O_FIFO);
    for (int i = 5; i < 8; i++)   tbl[i] = mk(1'b1, 16'd200, 1'b0, O_FIFO);
    for (int i = 8; i < 18; i++)  tbl[i] = mk(1'b0, 16'd100, 1'b0, O_DRN);
    tbl[18] = mk(1'b0, 16'd100, 1'b1, O_DRN);
    for (int i = 19; i < 23; i++) tbl[i] = mk(1'b0, 16'd100, 1'b1, O_SW1);
    tbl[23] = mk(1'b0, 16'd100, 1'b1, O_L2H);

    tick();
    tick();
    chk("reset_values", 32'(outs()), 32'(O_RST));

    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.meas_vld   = tbl[i].meas;
      bus.freq1      = 16'd100;
      bus.freq2      = tbl[i].f2;
      bus.fifo_empty = tbl[i].empty;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      @(posedge wclk);
      #1;
    end
    bus.meas_vld = 1'b0;

    // Hysteresis: 104 is in-band and must clear the count.
    do_reset();
    chk("resume_fifo_a", 32'(outs()), 32'(O_FIFO));
    strobe(16'd100, 16'd105);
    strobe(16'd100, 16'd105);
    strobe(16'd100, 16'd104);
    strobe(16'd100, 16'd103);
    strobe(16'd100, 16'd105);
    strobe(16'd100, 16'd105);
    chk("hyst_no_switch", 32'(outs()), 32'(O_FIFO));
    bus.fifo_empty = 1'b1;
    strobe(16'd100, 16'd105);
    chk("hyst_drain_entry", 32'(outs()), 32'(O_DRN));
    tick();
    chk("empty_one_cycle", 32'(outs()), 32'(O_SW1));
    repeat (3) tick();
    chk("swrst_c4", 32'(outs()), 32'(O_SW1));
    tick();
    chk("hyst_l2h", 32'(outs()), 32'(O_L2H));

    // Debounce break in l2h, then the fixed 8-cycle flush back to FIFO.
    bus.fifo_empty = 1'b0;
    strobe(16'd200, 16'd100);
    strobe(16'd200, 16'd200);
    strobe(16'd200, 16'd100);
    strobe(16'd200, 16'd100);
    chk("deb_break", 32'(outs()), 32'(O_L2H));
    strobe(16'd200, 16'd100);
    chk("flush_c1", 32'(outs()), 32'(6'b010110));
    repeat (7) tick();
    chk("flush_c8", 32'(outs()), 32'(6'b010110));
    tick();
    chk("flush_done", 32'(outs()), 32'(O_RST));
    repeat (4) tick();
    chk("back_fifo", 32'(outs()), 32'(O_FIFO));

    // Drain timeout with fifo_empty stuck low.
    strobe(16'd100, 16'd200);
    strobe(16'd100, 16'd200);
    strobe(16'd100, 16'd200);
    repeat (255) tick();
    chk("drain_c256", 32'(outs()), 32'(O_DRN));
    tick();
    chk("drain_timeout", 32'(outs()), 32'(6'b010011));
    repeat (4) tick();
    chk("derr_sticky", 32'(outs()), 32'(6'b110101));

    // Reset in the middle of SWRST.
    strobe(16'd200, 16'd100);
    strobe(16'd200, 16'd100);
    strobe(16'd200, 16'd100);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_switch", 32'(outs()), 32'(O_RST));
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("resume_fifo_b", 32'(outs()), 32'(O_FIFO));

`ifdef PATH_SWITCH_FORCE_EN
    bus.fifo_empty = 1'b1;
    bus.force_en   = 1'b1;
    bus.force_l2h  = 1'b1;
    repeat (6) tick();
    chk("force_l2h", 32'(outs()), 32'(O_L2H));
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
